instr_buffer: RTL



---
 rtl/instr_buffer_pkg.sv | 11 +
 rtl/instr_buffer_sync_fifo.sv | 31 +++
 rtl/instr_buffer.sv | 70 +++++++
 3 files changed

// File: rtl/instr_buffer_pkg.sv
// instr_buffer_pkg: shared constants and the buffered entry layout
package instr_buffer_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int DEFAULT_DEPTH = 2;
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] next_pc;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/instr_buffer_sync_fifo.sv
// sync_fifo: circular FIFO with wrapping pointers, occupancy count and flush
module sync_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= wdata;
  assign rdata = mem[rp];
endmodule

// File: rtl/instr_buffer.sv
// instr_buffer: fetch-to-decode instruction FIFO with squash and stale-response dropping
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        squash_i,
  input  logic        imem_req_i,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic [63:0] pc_i,
  input  logic [63:0] next_pc_i,
  input  logic        out_ready_i,
  output logic        out_valid_o,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  output logic [63:0] next_pc_o,
  output logic        full_o,
  output logic        overflow_o
);
  logic [CW-1:0] count;
  logic [1:0] outstanding, outstanding_next, drop_cnt;
  logic gnt, accept, push, pop;
  entry_t head;
  assign gnt = imem_req_i & imem_gnt_i;
  assign pop = out_valid_o & out_ready_i;
  assign accept = imem_rvalid_i & ~squash_i & (drop_cnt == 2'd0);
  assign push = accept & (~full_o | pop);
  assign out_valid_o = count != '0;
  assign full_o = count == CW'(DEPTH);
  always_comb begin
    outstanding_next = outstanding;
    if (gnt && !imem_rvalid_i)
      outstanding_next = (outstanding == 2'd3) ? 2'd3 : outstanding + 2'd1;
    else if (!gnt && imem_rvalid_i)
      outstanding_next = (outstanding == 2'd0) ? 2'd0 : outstanding - 2'd1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
      drop_cnt <= '0;
      overflow_o <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      overflow_o <= accept & full_o & ~pop;
      // the squash-cycle grant already fetches the redirected PC, so keep its response
      if (squash_i)
        drop_cnt <= (outstanding_next > {1'b0, gnt}) ? outstanding_next - {1'b0, gnt} : 2'd0;
      else if (imem_rvalid_i && drop_cnt != 2'd0)
        drop_cnt <= drop_cnt - 2'd1;
    end
  end
  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .flush(squash_i),
    .push(push),
    .pop(pop),
    .wdata({imem_rdata_i, pc_i, next_pc_i}),
    .rdata(head),
    .count(count)
  );
  assign instr_o = out_valid_o ? head.instr : NOP;
  assign pc_o = out_valid_o ? head.pc : 64'd0;
  assign next_pc_o = out_valid_o ? head.next_pc : 64'd0;
endmodule
